// File: rtl/crab_mem_ctrl.sv
// -----------------------------------------------------------------------------
// crab_mem_ctrl
//   Single-port 32-bit memory controller for the crabcore memory bus.
//   Handles one read or one write per request. Writes use byte enables built
//   from io_mode and the low address bits. Reads return the whole aligned word
//   after WAIT_CYCLES extra cycles and are closed by a toggle on mem_ack.
//
//   Memory contents are not initialised here. Each word is undefined until it
//   is first written, and contents survive reset.
//
// Parameters
//   ADDR_WIDTH   word-index bits; depth is 2**ADDR_WIDTH words
//   WAIT_CYCLES  extra cycles between read acceptance and mem_ready (0..15)
//
// Optional feature macro
//   CRAB_MEM_ALIGN_CHECK_EN  when defined, misaligned half/word accesses are
//                            flagged on mem_fault. Such a write is suppressed
//                            and such a read returns zero. When undefined,
//                            mem_fault is held at 0.
//
// Ports
//   clk             in   clock, rising edge
//   reset_n         in   synchronous active-low reset
//   mem_addr_valid  in   request valid
//   mem_addr        in   byte address (bits above ADDR_WIDTH+1 alias)
//   mem_data_valid  in   request is a write
//   mem_data        in   right-aligned write data
//   io_mode         in   0 byte, 1 half, other word
//   mem_ack         in   toggled by the core after it consumes read data
//   mem_ready       out  mem_input is valid
//   mem_input       out  read data, full aligned word
//   mem_write_done  out  write committed
//   mem_fault       out  misaligned access flag
// -----------------------------------------------------------------------------
module crab_mem_ctrl #(
  parameter int ADDR_WIDTH  = 13,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_addr_valid,
  input  logic [31:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_data,
  input  logic [2:0]  io_mode,
  input  logic        mem_ack,
  output logic        mem_ready,
  output logic [31:0] mem_input,
  output logic        mem_write_done,
  output logic        mem_fault
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  logic [31:0]           r_mem [DEPTH];
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ready,   w_ready_nxt;
  logic [31:0]           r_rdata,   w_rdata_nxt;
  logic                  r_wdone,   w_wdone_nxt;
  logic                  r_fault,   w_fault_nxt;
  logic [3:0]            r_cnt,     w_cnt_nxt;
  logic                  r_ack_cap, w_ack_nxt;
  logic [ADDR_WIDTH-1:0] r_idx,     w_idx_nxt;
  logic                  r_rd_mis,  w_rd_mis_nxt;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_wr_req;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic                  w_mis;
  logic                  w_mem_we;
  logic                  w_unused_addr;

  assign w_idx         = mem_addr[ADDR_WIDTH+1:2];
  assign w_wr_req      = mem_addr_valid & mem_data_valid;
  // Upper address bits alias onto the same words.
  assign w_unused_addr = ^mem_addr[31:ADDR_WIDTH+2];

  // Lane enables and lane-replicated write data from the access size.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_data;
    case (io_mode)
      3'd0: begin
        w_be    = 4'b0001 << mem_addr[1:0];
        w_wdata = {4{mem_data[7:0]}};
      end
      3'd1: begin
        w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mem_data;
      end
    endcase
  end

`ifdef CRAB_MEM_ALIGN_CHECK_EN
  // Misalignment: a half access on an odd byte, or a word access off a word boundary.
  always_comb begin
    case (io_mode)
      3'd0:    w_mis = 1'b0;
      3'd1:    w_mis = mem_addr[0];
      default: w_mis = (mem_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign w_mis = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wr_req) begin
          w_state_nxt = S_WRITE;
        end else if (mem_addr_valid) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? S_READ : S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_READ: begin
        if (mem_ack != r_ack_cap) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        if (!mem_data_valid) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the output registers and transaction bookkeeping.
  always_comb begin
    w_ready_nxt  = r_ready;
    w_rdata_nxt  = r_rdata;
    w_wdone_nxt  = r_wdone;
    w_fault_nxt  = r_fault;
    w_cnt_nxt    = r_cnt;
    w_ack_nxt    = r_ack_cap;
    w_idx_nxt    = r_idx;
    w_rd_mis_nxt = r_rd_mis;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_req) begin
          w_mem_we    = ~w_mis;
          w_wdone_nxt = 1'b1;
          w_fault_nxt = w_mis;
        end else if (mem_addr_valid) begin
          w_idx_nxt    = w_idx;
          w_ack_nxt    = mem_ack;
          w_rd_mis_nxt = w_mis;
          if (WAIT_CYCLES == 0) begin
            w_rdata_nxt = w_mis ? 32'h0000_0000 : r_mem[w_idx];
            w_ready_nxt = 1'b1;
            w_fault_nxt = w_mis;
          end else begin
            w_cnt_nxt = 4'(WAIT_CYCLES);
          end
        end else begin
          w_mem_we = 1'b0;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_rdata_nxt = r_rd_mis ? 32'h0000_0000 : r_mem[r_idx];
          w_ready_nxt = 1'b1;
          w_fault_nxt = r_rd_mis;
        end else begin
          w_ready_nxt = 1'b0;
        end
      end
      S_READ: begin
        if (mem_ack != r_ack_cap) begin
          w_ready_nxt = 1'b0;
          w_fault_nxt = 1'b0;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_WRITE: begin
        if (!mem_data_valid) begin
          w_wdone_nxt = 1'b0;
          w_fault_nxt = 1'b0;
        end else begin
          w_wdone_nxt = 1'b1;
        end
      end
      default: begin
        w_ready_nxt = 1'b0;
        w_wdone_nxt = 1'b0;
        w_fault_nxt = 1'b0;
      end
    endcase
  end

  // Output and bookkeeping registers. The captured ack follows the live ack during reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ready   <= 1'b0;
      r_rdata   <= 32'h0000_0000;
      r_wdone   <= 1'b0;
      r_fault   <= 1'b0;
      r_cnt     <= 4'd0;
      r_ack_cap <= mem_ack;
      r_idx     <= {ADDR_WIDTH{1'b0}};
      r_rd_mis  <= 1'b0;
    end else begin
      r_ready   <= w_ready_nxt;
      r_rdata   <= w_rdata_nxt;
      r_wdone   <= w_wdone_nxt;
      r_fault   <= w_fault_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ack_cap <= w_ack_nxt;
      r_idx     <= w_idx_nxt;
      r_rd_mis  <= w_rd_mis_nxt;
    end
  end

  // Memory array. It has no reset, and a write presented while reset is low is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_ready      = r_ready;
  assign mem_input      = r_rdata;
  assign mem_write_done = r_wdone;
  assign mem_fault      = r_fault;

endmodule
